// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller signal bundle: ID/EXE/MEM hazard inputs, SRAM handshake and
// pipeline control outputs. Perf counters appear only when HAZARD_PERF_EN is defined.
interface pipeline_hazard_ctrl_if;
  logic       fwd_en;
  logic [4:0] src1;
  logic [4:0] src2;
  logic       two_src;
  logic [4:0] Dest_EXE;
  logic       WB_EN_EXE;
  logic       MEM_R_EN_EXE;
  logic [4:0] Dest_MEM;
  logic       WB_EN_MEM;
  logic       mem_req;
  logic       mem_ready;
  logic       branch_taken;
  logic       freeze_pc;
  logic       bubble_exe;
  logic       flush_if;
  logic       freeze_all;
  logic       mem_timeout;
  logic [1:0] state;
`ifdef HAZARD_PERF_EN
  logic [15:0] perf_stall;
  logic [15:0] perf_memwait;
  logic [15:0] perf_flush;

  modport master (
    output fwd_en, src1, src2, two_src, Dest_EXE, WB_EN_EXE, MEM_R_EN_EXE,
           Dest_MEM, WB_EN_MEM, mem_req, mem_ready, branch_taken,
    input  freeze_pc, bubble_exe, flush_if, freeze_all, mem_timeout, state,
           perf_stall, perf_memwait, perf_flush
  );
  modport slave (
    input  fwd_en, src1, src2, two_src, Dest_EXE, WB_EN_EXE, MEM_R_EN_EXE,
           Dest_MEM, WB_EN_MEM, mem_req, mem_ready, branch_taken,
    output freeze_pc, bubble_exe, flush_if, freeze_all, mem_timeout, state,
           perf_stall, perf_memwait, perf_flush
  );
`else
  modport master (
    output fwd_en, src1, src2, two_src, Dest_EXE, WB_EN_EXE, MEM_R_EN_EXE,
           Dest_MEM, WB_EN_MEM, mem_req, mem_ready, branch_taken,
    input  freeze_pc, bubble_exe, flush_if, freeze_all, mem_timeout, state
  );
  modport slave (
    input  fwd_en, src1, src2, two_src, Dest_EXE, WB_EN_EXE, MEM_R_EN_EXE,
           Dest_MEM, WB_EN_MEM, mem_req, mem_ready, branch_taken,
    output freeze_pc, bubble_exe, flush_if, freeze_all, mem_timeout, state
  );
`endif
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: RAW/load-use stalls, SRAM wait freeze with timeout, deferred flush.
// Optional perf counters (perf_stall/perf_memwait/perf_flush) under macro HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 7
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMemWait = 2'b01,
    StErr     = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             br_pend_q, br_pend_d;
  logic             mem_timeout_q, mem_timeout_d;

  logic freeze_pc, bubble_exe, flush_if, freeze_all;
  logic m1_exe, m2_exe, m1_mem, m2_mem, hazard;

  always_comb begin
    m1_exe = (hz.src1 != 5'd0) && (hz.src1 == hz.Dest_EXE);
    m2_exe = hz.two_src && (hz.src2 != 5'd0) && (hz.src2 == hz.Dest_EXE);
    m1_mem = (hz.src1 != 5'd0) && (hz.src1 == hz.Dest_MEM);
    m2_mem = hz.two_src && (hz.src2 != 5'd0) && (hz.src2 == hz.Dest_MEM);
    // With forwarding on, only a load in EXE cannot be bypassed in time.
    if (hz.fwd_en) begin
      hazard = hz.MEM_R_EN_EXE && (m1_exe || m2_exe);
    end else begin
      hazard = (hz.WB_EN_EXE && (m1_exe || m2_exe)) || (hz.WB_EN_MEM && (m1_mem || m2_mem));
    end
  end

  always_comb begin
    freeze_pc     = 1'b0;
    bubble_exe    = 1'b0;
    flush_if      = 1'b0;
    freeze_all    = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    br_pend_d     = br_pend_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      StRun: begin
        if (hz.mem_req && !hz.mem_ready) begin
          freeze_all = 1'b1;
          freeze_pc  = 1'b1;
          if (hz.branch_taken) br_pend_d = 1'b1;
          state_d    = StMemWait;
          wait_cnt_d = CNT_W'(1);
        end else if (hz.branch_taken || br_pend_q) begin
          // ID holds a wrong-path instruction, so any hazard on it is moot.
          flush_if   = 1'b1;
          bubble_exe = 1'b1;
          br_pend_d  = 1'b0;
        end else if (hazard) begin
          freeze_pc  = 1'b1;
          bubble_exe = 1'b1;
        end
      end
      StMemWait: begin
        if (hz.branch_taken) br_pend_d = 1'b1;
        if (hz.mem_ready) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else begin
          freeze_all = 1'b1;
          freeze_pc  = 1'b1;
          if (wait_cnt_q == CntMax) begin
            state_d       = StErr;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
      end
      StErr: begin
        freeze_all    = 1'b1;
        freeze_pc     = 1'b1;
        mem_timeout_d = 1'b1;
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StRun;
      wait_cnt_q    <= '0;
      br_pend_q     <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      br_pend_q     <= br_pend_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign hz.freeze_pc   = freeze_pc;
  assign hz.bubble_exe  = bubble_exe;
  assign hz.flush_if    = flush_if;
  assign hz.freeze_all  = freeze_all;
  assign hz.mem_timeout = mem_timeout_q;
  assign hz.state       = state_q;

`ifdef HAZARD_PERF_EN
  logic [15:0] perf_stall_q, perf_memwait_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q   <= '0;
      perf_memwait_q <= '0;
      perf_flush_q   <= '0;
    end else begin
      if ((state_q == StRun) && bubble_exe && !flush_if && (perf_stall_q != 16'hFFFF)) begin
        perf_stall_q <= perf_stall_q + 16'd1;
      end
      if (freeze_all && (perf_memwait_q != 16'hFFFF)) begin
        perf_memwait_q <= perf_memwait_q + 16'd1;
      end
      if (flush_if && (perf_flush_q != 16'hFFFF)) begin
        perf_flush_q <= perf_flush_q + 16'd1;
      end
    end
  end

  assign hz.perf_stall   = perf_stall_q;
  assign hz.perf_memwait = perf_memwait_q;
  assign hz.perf_flush   = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=8); outputs checked as the
// packed vector {freeze_pc, bubble_exe, flush_if, freeze_all, mem_timeout}.
module tb_pipeline_hazard_ctrl;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_checks;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(8),
    .CNT_W      (7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] outs();
    return {27'd0, hz.freeze_pc, hz.bubble_exe, hz.flush_if, hz.freeze_all, hz.mem_timeout};
  endfunction

  // Advance past the next rising edge; inputs then change and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.fwd_en       = 1'b1;
    hz.src1         = 5'd0;
    hz.src2         = 5'd0;
    hz.two_src      = 1'b0;
    hz.Dest_EXE     = 5'd0;
    hz.WB_EN_EXE    = 1'b0;
    hz.MEM_R_EN_EXE = 1'b0;
    hz.Dest_MEM     = 5'd0;
    hz.WB_EN_MEM    = 1'b0;
    hz.mem_req      = 1'b0;
    hz.mem_ready    = 1'b0;
    hz.branch_taken = 1'b0;
  endtask

  initial begin
    n_pass   = 0;
    n_checks = 0;
    rst      = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_state", 32'(hz.state), 32'd0);
    check("reset_outs", outs(), 32'b00000);

    // Load-use with forwarding on
    hz.fwd_en = 1'b1; hz.MEM_R_EN_EXE = 1'b1; hz.WB_EN_EXE = 1'b1;
    hz.Dest_EXE = 5'd5; hz.src1 = 5'd5;
    #1 check("load_use", outs(), 32'b11000);
    hz.src1 = 5'd0; hz.Dest_EXE = 5'd0;
    #1 check("load_use_r0", outs(), 32'b00000);
    hz.MEM_R_EN_EXE = 1'b0; hz.Dest_EXE = 5'd5; hz.src1 = 5'd5;
    #1 check("alu_fwd_nostall", outs(), 32'b00000);

    // Forwarding off
    idle();
    hz.fwd_en = 1'b0; hz.WB_EN_MEM = 1'b1; hz.Dest_MEM = 5'd7;
    hz.two_src = 1'b1; hz.src2 = 5'd7;
    #1 check("nofwd_mem_src2", outs(), 32'b11000);
    hz.two_src = 1'b0;
    #1 check("nofwd_imm", outs(), 32'b00000);
    idle();
    hz.fwd_en = 1'b0; hz.WB_EN_EXE = 1'b1; hz.Dest_EXE = 5'd3; hz.src1 = 5'd3;
    #1 check("nofwd_exe_src1", outs(), 32'b11000);

    // Branch beats load-use hazard
    idle();
    hz.MEM_R_EN_EXE = 1'b1; hz.Dest_EXE = 5'd5; hz.src1 = 5'd5; hz.branch_taken = 1'b1;
    #1 check("branch_vs_hazard", outs(), 32'b01100);
    tick();
    idle();
    #1 check("branch_no_pend", outs(), 32'b00000);

    // SRAM wait of 4 frozen cycles with a branch pulse while frozen
    hz.mem_req = 1'b1;
    #1 check("wait_c1", outs(), 32'b10010);
    check("wait_c1_state", 32'(hz.state), 32'd0);
    tick();
    check("wait_c2", outs(), 32'b10010);
    check("wait_c2_state", 32'(hz.state), 32'd1);
    tick();
    hz.branch_taken = 1'b1;
    #1 check("wait_c3_branch", outs(), 32'b10010);
    tick();
    hz.branch_taken = 1'b0;
    #1 check("wait_c4", outs(), 32'b10010);
    tick();
    hz.mem_ready = 1'b1;
    #1 check("wait_c5_release", 32'(hz.freeze_all), 32'd0);
    check("wait_c5_noflush", 32'(hz.flush_if), 32'd0);
    tick();
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
    #1 check("deferred_state", 32'(hz.state), 32'd0);
    check("deferred_flush", outs(), 32'b01100);
    tick();
    check("deferred_once", outs(), 32'b00000);

    // Single-cycle SRAM access
    hz.mem_req = 1'b1; hz.mem_ready = 1'b1;
    #1 check("single_cycle_mem", outs(), 32'b00000);
    tick();
    check("single_cycle_state", 32'(hz.state), 32'd0);
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0;

    // Timeout after 8 frozen cycles
    hz.mem_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 check("to_frozen", outs(), 32'b10010);
      check("to_state", 32'(hz.state), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    check("to_err_state", 32'(hz.state), 32'd2);
    check("to_err_outs", outs(), 32'b10011);
    hz.mem_req = 1'b0;
    tick();
    tick();
    check("to_err_sticky", outs(), 32'b10011);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 check("err_reset_state", 32'(hz.state), 32'd0);
    check("err_reset_outs", outs(), 32'b00000);

    // Reset in the middle of a memory wait
    hz.mem_req = 1'b1;
    tick();
    tick();
    check("mid_wait_state", 32'(hz.state), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hz.mem_req = 1'b0;
    #1 check("mid_wait_rst_state", 32'(hz.state), 32'd0);
    check("mid_wait_rst_outs", outs(), 32'b00000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. Sits beside the forwarding unit.
- Detects RAW hazards the forwarding unit cannot cover: all RAW hazards with forwarding off, and load-use hazards with forwarding on.
- Holds the whole pipeline while the SRAM controller completes a MEM-stage access, and flushes wrong-path instructions on a taken branch.
- Owns a small FSM with a memory-wait timeout counter and a deferred-flush latch.

Parameters:
- MEM_TIMEOUT, 64: max MEMWAIT cycles before the error state (≥2).
- CNT_W, 7: width of the wait counter; must hold MEM_TIMEOUT-1.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous reset, active-high.
- fwd_en  in  1  forwarding enabled.
- src1  in  5  ID-stage source register 1.
- src2  in  5  ID-stage source register 2.
- two_src  in  1  ID instruction reads src2 as a register (not an immediate).
- Dest_EXE  in  5  EXE-stage destination register.
- WB_EN_EXE  in  1  EXE-stage write-back enable.
- MEM_R_EN_EXE  in  1  EXE-stage instruction is a load.
- Dest_MEM  in  5  MEM-stage destination register.
- WB_EN_MEM  in  1  MEM-stage write-back enable.
- mem_req  in  1  MEM stage holds a load or store.
- mem_ready  in  1  SRAM access completes this cycle.
- branch_taken  in  1  EXE-stage branch resolved taken.
- freeze_pc  out  1  hold PC and IF/ID register.
- bubble_exe  out  1  load NOP into ID/EXE.
- flush_if  out  1  load NOP into IF/ID.
- freeze_all  out  1  hold ID/EXE, EXE/MEM, MEM/WB.
- mem_timeout  out  1  sticky error flag.
- state  out  2  FSM state, for debug.

Behaviour:
- FSM states: RUN=2'b00, MEMWAIT=2'b01, ERR=2'b10. Code 2'b11 is unreachable and recovers to RUN.
- Outputs are Mealy, computed from state and current inputs. Only state, wait_cnt, br_pend and mem_timeout are registered.
- Reset values: state=RUN, wait_cnt=0, br_pend=0, mem_timeout=0. With idle inputs, all outputs are 0.
- Reset has priority over every event, including mid-MEMWAIT and ERR.

Hazard term H:
- m1 = (src1 != 0) && (src1 == Dest_EXE).
- m2 = two_src && (src2 != 0) && (src2 == Dest_EXE).
- With fwd_en=1: H = MEM_R_EN_EXE && (m1 || m2).
- With fwd_en=0: H = (WB_EN_EXE && (m1 || m2)) || (WB_EN_MEM && matches against Dest_MEM, same form as m1/m2).
- Register 0 never hazards.

RUN state, evaluated in this priority order:
1. mem_req && !mem_ready:
   - freeze_all=1, freeze_pc=1, bubble_exe=0, flush_if=0.
   - If branch_taken, set br_pend.
   - Next state MEMWAIT, wait_cnt=1.
2. branch_taken || br_pend:
   - flush_if=1, bubble_exe=1, freeze_pc=0. The hazard is ignored because the ID instruction is wrong-path.
   - Clear br_pend.
3. H: freeze_pc=1, bubble_exe=1. Stay in RUN.
4. Otherwise all outputs 0.

MEMWAIT state:
- freeze_all=1 and freeze_pc=1 every cycle; bubble_exe=0, flush_if=0.
- branch_taken sets br_pend. It is held in EXE and is also sampled while frozen.
- On mem_ready: freeze_all=0 in that same cycle, next state RUN, wait_cnt=0. The pending flush is applied in the next RUN cycle via priority 2.
- Else if wait_cnt == MEM_TIMEOUT-1: next state ERR, set mem_timeout.
- Else wait_cnt += 1.

ERR state:
- freeze_all=1, freeze_pc=1, mem_timeout=1.
- Exits only on rst.

Latency:
- Hazard stall and flush are 0-cycle, in the same cycle as the inputs.
- A single-cycle SRAM access (mem_ready with mem_req) causes no stall.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds three 16-bit saturating outputs, all cleared by rst:
  - perf_stall: counts cycles with RUN && bubble_exe && !flush_if.
  - perf_memwait: counts cycles with freeze_all=1.
  - perf_flush: counts cycles with flush_if=1.
- Counters saturate at 16'hFFFF; there is no wrap.
- When undefined, these ports and registers are absent. All other behaviour is identical.

Test Plan:
- Load-use stall: fwd_en=1, MEM_R_EN_EXE=1, WB_EN_EXE=1, Dest_EXE=5, src1=5 -> same cycle freeze_pc=1, bubble_exe=1. Set src1=0 with Dest_EXE=0 -> no stall.
- Forwarding off: fwd_en=0, WB_EN_MEM=1, Dest_MEM=7, two_src=1, src2=7 -> freeze_pc=1, bubble_exe=1. Clear two_src -> no stall.
- SRAM wait: mem_req=1 with mem_ready low for 4 cycles, then high -> freeze_all=1 for exactly 4 cycles, state 01 during the wait. Cycle 5 freeze_all=0, then RUN.
- Deferred flush: branch_taken pulsed during MEMWAIT -> no flush while frozen. flush_if=1 and bubble_exe=1 in the first RUN cycle after mem_ready, exactly once.
- Simultaneous branch and hazard: branch_taken=1 with a load-use hazard present -> flush_if=1, bubble_exe=1, freeze_pc=0.
- Timeout and reset: MEM_TIMEOUT=8, mem_ready held low -> after 8 frozen cycles state=10 and mem_timeout=1, held until rst. rst asserted mid-MEMWAIT -> next cycle state=00, all outputs 0.
